// File: rtl/lc3b_control_if.sv
// lc3b_control_if
//   Bundle between the LC-3b control FSM and the datapath it sequences.
//   master modport : control side (drives loads, gates, selects, ALUK, SRAM strobes;
//                    reads opcode, BEN, imm5_sel_out)
//   slave modport  : datapath/SRAM side (mirror image)
//   ALUK encoding (lc3b_aluop): 00 ADD, 01 AND, 10 NOT, 11 PASSA.
//   Mem_CE / Mem_OE / Mem_WE are active-low.
interface lc3b_control_if;
   logic [3:0] opcode;
   logic       BEN;
   logic       imm5_sel_out;

   logic       load_ir;
   logic       load_pc;
   logic       load_mar;
   logic       load_mdr;
   logic       ld_reg;

   logic       GatePC;
   logic       GateMDR;
   logic       GateALU;
   logic       GateMARMUX;

   logic [1:0] pc_sel;
   logic       addr1mux_sel;
   logic [1:0] addr2mux_sel;
   logic       SR1_mux_sel;
   logic       SR2_mux_sel;
   logic [1:0] ALUK;

   logic       Mem_CE;
   logic       Mem_OE;
   logic       Mem_WE;

   modport master (
      input  opcode, BEN, imm5_sel_out,
      output load_ir, load_pc, load_mar, load_mdr, ld_reg,
      output GatePC, GateMDR, GateALU, GateMARMUX,
      output pc_sel, addr1mux_sel, addr2mux_sel, SR1_mux_sel, SR2_mux_sel, ALUK,
      output Mem_CE, Mem_OE, Mem_WE
   );

   modport slave (
      output opcode, BEN, imm5_sel_out,
      input  load_ir, load_pc, load_mar, load_mdr, ld_reg,
      input  GatePC, GateMDR, GateALU, GateMARMUX,
      input  pc_sel, addr1mux_sel, addr2mux_sel, SR1_mux_sel, SR2_mux_sel, ALUK,
      input  Mem_CE, Mem_OE, Mem_WE
   );
endinterface

// File: rtl/lc3b_control.sv
// lc3b_control
//   Multi-cycle fetch/decode/execute control FSM for the LC-3b-subset datapath,
//   including the active-low SRAM strobes and a Run/Continue front-panel handshake.
//   Ports:
//     Clk        system clock, rising edge
//     Reset      synchronous, active-high; forces HALT on the next edge
//     Run        start from HALT (level, ignored elsewhere)
//     Continue   resume from PAUSE (level, must be released before fetch resumes)
//     dp         lc3b_control_if.master: datapath status in, all control out
//     state_dbg  current state encoding for LEDs/debug
//   Parameter MEM_CYCLES (2..4): SRAM strobe length per access; last cycle commits.
//   Optional macro LC3B_CTRL_PCINC_LATE_EN: PC increment moves from FETCH_MAR
//   to FETCH_IR so the PC stays stable on the bus side during the read.
//
//   state      | meaning
//   -----------+-----------------------------------------------
//   HALT       | idle, waits for Run
//   FETCH_MAR  | PC -> MAR (and PC+1 unless late increment)
//   FETCH_RD   | SRAM read, MEM_CYCLES long, MDR loads on last
//   FETCH_IR   | MDR -> IR
//   DECODE     | branch on opcode
//   EX_ALU     | ADD / AND / NOT writeback
//   BR_EVAL    | sample BEN
//   BR_TAKE    | PC <= PC + off9
//   JMP        | PC <= SR1
//   LDR_ADDR   | MAR <= SR1 + off6
//   LDR_RD     | SRAM read, MEM_CYCLES long
//   LDR_WB     | MDR -> DR
//   STR_ADDR   | MAR <= SR1 + off6
//   STR_DATA   | MDR <= SR (IR[11:9]) via PASSA
//   STR_WR     | SRAM write, WE low on all but the last cycle
//   PAUSE_HI   | wait for Continue high
//   PAUSE_LO   | wait for Continue release
module lc3b_control #(
   parameter int MEM_CYCLES = 2
) (
   input  logic                  Clk,
   input  logic                  Reset,
   input  logic                  Run,
   input  logic                  Continue,
   lc3b_control_if.master        dp,
   output logic [4:0]            state_dbg
);

   localparam logic [4:0] S_HALT      = 5'd0;
   localparam logic [4:0] S_FETCH_MAR = 5'd1;
   localparam logic [4:0] S_FETCH_RD  = 5'd2;
   localparam logic [4:0] S_FETCH_IR  = 5'd3;
   localparam logic [4:0] S_DECODE    = 5'd4;
   localparam logic [4:0] S_EX_ALU    = 5'd5;
   localparam logic [4:0] S_BR_EVAL   = 5'd6;
   localparam logic [4:0] S_BR_TAKE   = 5'd7;
   localparam logic [4:0] S_JMP       = 5'd8;
   localparam logic [4:0] S_LDR_ADDR  = 5'd9;
   localparam logic [4:0] S_LDR_RD    = 5'd10;
   localparam logic [4:0] S_LDR_WB    = 5'd11;
   localparam logic [4:0] S_STR_ADDR  = 5'd12;
   localparam logic [4:0] S_STR_DATA  = 5'd13;
   localparam logic [4:0] S_STR_WR    = 5'd14;
   localparam logic [4:0] S_PAUSE_HI  = 5'd15;
   localparam logic [4:0] S_PAUSE_LO  = 5'd16;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_AND   = 2'b01;
   localparam logic [1:0] ALU_NOT   = 2'b10;
   localparam logic [1:0] ALU_PASSA = 2'b11;

   localparam logic [1:0] MEM_LOAD = 2'(MEM_CYCLES - 1);

   logic [4:0] state;
   logic [4:0] state_next;
   logic [1:0] mem_cnt;
   logic       mem_last;

   // Down-counter reloaded on every state change; terminal count marks the
   // commit cycle of a memory access.
   assign mem_last  = (mem_cnt == 2'd0);
   assign state_dbg = state;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state   <= S_HALT;
         mem_cnt <= MEM_LOAD;
      end else begin
         state <= state_next;
         if (state_next != state)
            mem_cnt <= MEM_LOAD;
         else if (!mem_last)
            mem_cnt <= mem_cnt - 2'd1;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         S_HALT:      if (Run) state_next = S_FETCH_MAR;
         S_FETCH_MAR: state_next = S_FETCH_RD;
         S_FETCH_RD:  if (mem_last) state_next = S_FETCH_IR;
         S_FETCH_IR:  state_next = S_DECODE;
         S_DECODE: begin
            case (dp.opcode)
               4'b0001, 4'b0101, 4'b1001: state_next = S_EX_ALU;
               4'b0000:                   state_next = S_BR_EVAL;
               4'b1100:                   state_next = S_JMP;
               4'b0110:                   state_next = S_LDR_ADDR;
               4'b0111:                   state_next = S_STR_ADDR;
               4'b1101:                   state_next = S_PAUSE_HI;
               default:                   state_next = S_FETCH_MAR;
            endcase
         end
         S_EX_ALU:    state_next = S_FETCH_MAR;
         S_BR_EVAL:   state_next = dp.BEN ? S_BR_TAKE : S_FETCH_MAR;
         S_BR_TAKE:   state_next = S_FETCH_MAR;
         S_JMP:       state_next = S_FETCH_MAR;
         S_LDR_ADDR:  state_next = S_LDR_RD;
         S_LDR_RD:    if (mem_last) state_next = S_LDR_WB;
         S_LDR_WB:    state_next = S_FETCH_MAR;
         S_STR_ADDR:  state_next = S_STR_DATA;
         S_STR_DATA:  state_next = S_STR_WR;
         S_STR_WR:    if (mem_last) state_next = S_FETCH_MAR;
         S_PAUSE_HI:  if (Continue) state_next = S_PAUSE_LO;
         S_PAUSE_LO:  if (!Continue) state_next = S_FETCH_MAR;
         default:     state_next = S_HALT;
      endcase
   end

   always_comb begin
      dp.load_ir      = 1'b0;
      dp.load_pc      = 1'b0;
      dp.load_mar     = 1'b0;
      dp.load_mdr     = 1'b0;
      dp.ld_reg       = 1'b0;
      dp.GatePC       = 1'b0;
      dp.GateMDR      = 1'b0;
      dp.GateALU      = 1'b0;
      dp.GateMARMUX   = 1'b0;
      dp.pc_sel       = 2'b00;
      dp.addr1mux_sel = 1'b0;
      dp.addr2mux_sel = 2'b00;
      dp.SR1_mux_sel  = 1'b0;
      dp.SR2_mux_sel  = 1'b0;
      dp.ALUK         = ALU_ADD;
      dp.Mem_CE       = 1'b1;
      dp.Mem_OE       = 1'b1;
      dp.Mem_WE       = 1'b1;
      case (state)
         S_FETCH_MAR: begin
            dp.GatePC   = 1'b1;
            dp.load_mar = 1'b1;
`ifndef LC3B_CTRL_PCINC_LATE_EN
            dp.pc_sel   = 2'b01;
            dp.load_pc  = 1'b1;
`endif
         end
         S_FETCH_RD, S_LDR_RD: begin
            dp.Mem_CE   = 1'b0;
            dp.Mem_OE   = 1'b0;
            dp.load_mdr = mem_last;
         end
         S_FETCH_IR: begin
            dp.GateMDR = 1'b1;
            dp.load_ir = 1'b1;
`ifdef LC3B_CTRL_PCINC_LATE_EN
            dp.pc_sel  = 2'b01;
            dp.load_pc = 1'b1;
`endif
         end
         S_EX_ALU: begin
            dp.GateALU = 1'b1;
            dp.ld_reg  = 1'b1;
            case (dp.opcode)
               4'b0101: dp.ALUK = ALU_AND;
               4'b1001: dp.ALUK = ALU_NOT;
               default: dp.ALUK = ALU_ADD;
            endcase
            // NOT has no second operand, so the imm5 select is forced off.
            dp.SR2_mux_sel = (dp.opcode == 4'b1001) ? 1'b0 : dp.imm5_sel_out;
         end
         S_BR_TAKE: begin
            dp.addr1mux_sel = 1'b0;
            dp.addr2mux_sel = 2'b10;
            dp.pc_sel       = 2'b10;
            dp.load_pc      = 1'b1;
         end
         S_JMP: begin
            dp.addr1mux_sel = 1'b1;
            dp.addr2mux_sel = 2'b00;
            dp.pc_sel       = 2'b10;
            dp.load_pc      = 1'b1;
            dp.SR1_mux_sel  = 1'b0;
         end
         S_LDR_ADDR, S_STR_ADDR: begin
            dp.SR1_mux_sel  = 1'b0;
            dp.addr1mux_sel = 1'b1;
            dp.addr2mux_sel = 2'b01;
            dp.GateMARMUX   = 1'b1;
            dp.load_mar     = 1'b1;
         end
         S_LDR_WB: begin
            dp.GateMDR = 1'b1;
            dp.ld_reg  = 1'b1;
         end
         S_STR_DATA: begin
            dp.SR1_mux_sel = 1'b1;
            dp.ALUK        = ALU_PASSA;
            dp.GateALU     = 1'b1;
            dp.load_mdr    = 1'b1;
         end
         S_STR_WR: begin
            // WE rises one cycle before CE/MDR drop so the SRAM sees data hold.
            dp.GateMDR = 1'b1;
            dp.Mem_CE  = 1'b0;
            dp.Mem_WE  = mem_last;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_lc3b_control.sv
module tb_lc3b_control;

   typedef struct packed {
      logic       load_ir, load_pc, load_mar, load_mdr, ld_reg;
      logic       gate_pc, gate_mdr, gate_alu, gate_marmux;
      logic [1:0] pc_sel;
      logic       addr1;
      logic [1:0] addr2;
      logic       sr1, sr2;
      logic [1:0] aluk;
      logic       ce, oe, we;
   } ctl_t;

   logic       Clk = 1'b0;
   logic       Reset = 1'b1;
   logic       Run = 1'b0;
   logic       Continue = 1'b0;
   logic [3:0] opcode = 4'h0;
   logic       ben = 1'b0;
   logic       imm = 1'b0;
   logic [4:0] state_dbg2, state_dbg3;
   logic       sel = 1'b0;
   logic       run_noise = 1'b0;
   int         n_cmp = 0;
   int         n_bad = 0;

   always #5 Clk = ~Clk;

   lc3b_control_if bus2 ();
   lc3b_control_if bus3 ();

   assign bus2.opcode = opcode;
   assign bus2.BEN = ben;
   assign bus2.imm5_sel_out = imm;
   assign bus3.opcode = opcode;
   assign bus3.BEN = ben;
   assign bus3.imm5_sel_out = imm;

   lc3b_control #(.MEM_CYCLES(2)) dut2 (
      .Clk(Clk), .Reset(Reset), .Run(Run), .Continue(Continue),
      .dp(bus2), .state_dbg(state_dbg2));

   lc3b_control #(.MEM_CYCLES(3)) dut3 (
      .Clk(Clk), .Reset(Reset), .Run(Run), .Continue(Continue),
      .dp(bus3), .state_dbg(state_dbg3));

   logic [20:0] obs2, obs3;
   assign obs2 = {bus2.load_ir, bus2.load_pc, bus2.load_mar, bus2.load_mdr, bus2.ld_reg,
                  bus2.GatePC, bus2.GateMDR, bus2.GateALU, bus2.GateMARMUX,
                  bus2.pc_sel, bus2.addr1mux_sel, bus2.addr2mux_sel,
                  bus2.SR1_mux_sel, bus2.SR2_mux_sel, bus2.ALUK,
                  bus2.Mem_CE, bus2.Mem_OE, bus2.Mem_WE};
   assign obs3 = {bus3.load_ir, bus3.load_pc, bus3.load_mar, bus3.load_mdr, bus3.ld_reg,
                  bus3.GatePC, bus3.GateMDR, bus3.GateALU, bus3.GateMARMUX,
                  bus3.pc_sel, bus3.addr1mux_sel, bus3.addr2mux_sel,
                  bus3.SR1_mux_sel, bus3.SR2_mux_sel, bus3.ALUK,
                  bus3.Mem_CE, bus3.Mem_OE, bus3.Mem_WE};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s (mc=%0d) t=%0t: got %h expected %h", tag, sel ? 3 : 2, $time, got, exp);
      end
   endtask

   function automatic ctl_t dflt();
      ctl_t c;
      c = '0;
      c.ce = 1'b1;
      c.oe = 1'b1;
      c.we = 1'b1;
      return c;
   endfunction

   // One clock: sample mid-cycle, compare the full control word and the bus invariants.
   task automatic step(input string tag, input ctl_t e);
      ctl_t o;
      @(negedge Clk);
      o = sel ? obs3 : obs2;
      check(tag, 32'(o), 32'(e));
      check({tag, "/one_gate"},
            32'($countones({o.gate_pc, o.gate_mdr, o.gate_alu, o.gate_marmux}) <= 1), 32'd1);
      check({tag, "/oe_we"}, 32'(!(!o.oe && !o.we)), 32'd1);
      if (run_noise) Run = 1'($urandom_range(0, 1));
   endtask

   // Expected per-cycle control words for one instruction, from MAR through its last cycle.
   task automatic run_instr(input int mc, input logic [3:0] op, input logic im,
                            input logic b, input bit abort_wr);
      ctl_t e;
      e = dflt();
      e.gate_pc = 1'b1;
      e.load_mar = 1'b1;
`ifndef LC3B_CTRL_PCINC_LATE_EN
      e.pc_sel = 2'b01;
      e.load_pc = 1'b1;
`endif
      step("fetch_mar", e);
      opcode = op;
      imm = im;
      ben = b;
      for (int i = 0; i < mc; i++) begin
         e = dflt();
         e.ce = 1'b0;
         e.oe = 1'b0;
         e.load_mdr = (i == mc - 1);
         step("fetch_rd", e);
      end
      e = dflt();
      e.gate_mdr = 1'b1;
      e.load_ir = 1'b1;
`ifdef LC3B_CTRL_PCINC_LATE_EN
      e.pc_sel = 2'b01;
      e.load_pc = 1'b1;
`endif
      step("fetch_ir", e);
      step("decode", dflt());
      case (op)
         4'b0001, 4'b0101, 4'b1001: begin
            e = dflt();
            e.gate_alu = 1'b1;
            e.ld_reg = 1'b1;
            e.aluk = (op == 4'b0101) ? 2'b01 : (op == 4'b1001) ? 2'b10 : 2'b00;
            e.sr2 = (op == 4'b1001) ? 1'b0 : im;
            step("ex_alu", e);
         end
         4'b0000: begin
            step("br_eval", dflt());
            if (b) begin
               e = dflt();
               e.addr2 = 2'b10;
               e.pc_sel = 2'b10;
               e.load_pc = 1'b1;
               step("br_take", e);
            end
         end
         4'b1100: begin
            e = dflt();
            e.addr1 = 1'b1;
            e.pc_sel = 2'b10;
            e.load_pc = 1'b1;
            step("jmp", e);
         end
         4'b0110, 4'b0111: begin
            e = dflt();
            e.addr1 = 1'b1;
            e.addr2 = 2'b01;
            e.gate_marmux = 1'b1;
            e.load_mar = 1'b1;
            step("mem_addr", e);
            if (op == 4'b0110) begin
               for (int i = 0; i < mc; i++) begin
                  e = dflt();
                  e.ce = 1'b0;
                  e.oe = 1'b0;
                  e.load_mdr = (i == mc - 1);
                  step("ldr_rd", e);
               end
               e = dflt();
               e.gate_mdr = 1'b1;
               e.ld_reg = 1'b1;
               step("ldr_wb", e);
            end else begin
               e = dflt();
               e.sr1 = 1'b1;
               e.aluk = 2'b11;
               e.gate_alu = 1'b1;
               e.load_mdr = 1'b1;
               step("str_data", e);
               for (int i = 0; i < mc; i++) begin
                  e = dflt();
                  e.gate_mdr = 1'b1;
                  e.ce = 1'b0;
                  e.we = (i == mc - 1);
                  step("str_wr", e);
                  if (abort_wr) begin
                     Reset = 1'b1;
                     Run = 1'b0;
                     run_noise = 1'b0;
                     step("rst_halt", dflt());
                     Reset = 1'b0;
                     step("halt_hold", dflt());
                     Run = 1'b1;
                     return;
                  end
               end
            end
         end
         4'b1101: begin
            int w, h;
            w = $urandom_range(0, 2);
            h = $urandom_range(2, 5);
            Continue = 1'b0;
            repeat (w) step("pause_wait", dflt());
            Continue = 1'b1;
            repeat (h) step("pause_hold", dflt());
            Continue = 1'b0;
         end
         default: ;
      endcase
   endtask

   task automatic run_phase(input int mc);
      logic [3:0] op;
      Reset = 1'b1;
      Run = 1'b0;
      Continue = 1'b0;
      run_noise = 1'b0;
      repeat (2) @(negedge Clk);
      Reset = 1'b0;
      repeat (3) step("halt_idle", dflt());
      Run = 1'b1;
      run_instr(mc, 4'b0001, 1'b1, 1'b0, 1'b0);
      run_noise = 1'b1;
      run_instr(mc, 4'b0000, 1'b0, 1'b0, 1'b0);
      run_instr(mc, 4'b0000, 1'b0, 1'b1, 1'b0);
      run_instr(mc, 4'b0111, 1'b0, 1'b0, 1'b0);
      run_instr(mc, 4'b1101, 1'b0, 1'b0, 1'b0);
      run_instr(mc, 4'b1111, 1'b0, 1'b0, 1'b0);
      run_instr(mc, 4'b1100, 1'b0, 1'b0, 1'b0);
      run_instr(mc, 4'b0110, 1'b0, 1'b0, 1'b0);
      run_instr(mc, 4'b0101, 1'b0, 1'b0, 1'b0);
      run_instr(mc, 4'b1001, 1'b1, 1'b0, 1'b0);
      for (int k = 0; k < 40; k++) begin
         op = 4'($urandom_range(0, 15));
         run_instr(mc, op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
      end
      run_instr(mc, 4'b0111, 1'b0, 1'b0, 1'b1);
      run_instr(mc, 4'b0001, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      sel = 1'b0;
      run_phase(2);
      sel = 1'b1;
      run_phase(3);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
